// File: rtl/add_sub_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer and its slice.
package add_sub_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int NWORDS_DEF = 4;

    // State encoding; the unused code 2'd3 recovers to IDLE.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE,
        ST_BAD  = 2'd3
    } state_t;

endpackage

// File: rtl/mw_add_sub_seq_if.sv
// Request/result bundle of the multi-word add/subtract sequencer.
//
// Handshake: both channels are valid/ready. A request transfers on a rising
// edge where i_valid and o_ready are both 1; a result transfers on a rising
// edge where o_valid and i_ready are both 1. o_ready and o_valid are
// registered and never depend combinationally on i_valid or i_ready. Once
// o_valid is high, o_result and the flags hold until the transfer edge.
interface mw_add_sub_seq_if #(
    parameter int WIDTH  = 8,
    parameter int NWORDS = 4
);
    localparam int W = WIDTH * NWORDS;

    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_add_sub;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_result;
    logic         o_cout;
    logic         o_ovf;
    logic         o_zero;

    modport master (
        output i_valid, i_a, i_b, i_add_sub, i_ready,
        input  o_ready, o_valid, o_result, o_cout, o_ovf, o_zero
    );

    modport slave (
        input  i_valid, i_a, i_b, i_add_sub, i_ready,
        output o_ready, o_valid, o_result, o_cout, o_ovf, o_zero
    );

endinterface

// File: rtl/mw_add_sub_seq_add_sub.sv
// Single-word add/subtract slice: sel=1 inverts b so that cin=1 completes
// the two's-complement subtract. Purely combinational.
module add_sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sel,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b ^ {WIDTH{sel}}} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/mw_add_sub_seq.sv
// Multi-word add/subtract sequencer: accepts one wide operation, walks it
// through the single-word slice LSW first with a registered carry, and
// returns the full result with carry, signed-overflow and zero flags.
module mw_add_sub_seq
    import add_sub_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NWORDS = NWORDS_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    mw_add_sub_seq_if.slave   bus,
    output logic [1:0]        o_dbg_state
);

    localparam int IDX_W = (NWORDS > 2) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

    state_t state_q, state_d;

    logic [NWORDS-1:0][WIDTH-1:0] a_q, b_q, res_q, res_final;
    logic                         op_q;
    logic                         carry_q;
    logic [IDX_W-1:0]             idx_q;

    logic [WIDTH-1:0] sl_a, sl_b, sl_sum;
    logic             sl_cout;

    logic accept, step, finish;
    logic ready_d, valid_d;

    assign sl_a        = a_q[idx_q];
    assign sl_b        = b_q[idx_q];
    assign o_dbg_state = state_q;

    add_sub #(.WIDTH(WIDTH)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sel  (op_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    // Next-state and control strobes; handshake outputs follow the next state.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.o_ready && bus.i_valid) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (idx_q == IDX_LAST) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.i_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_DONE);
    end

    // Final result: lower words already registered, top word straight from the slice.
    always_comb begin
        res_final             = res_q;
        res_final[NWORDS-1]   = sl_sum;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered handshake outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_ready <= 1'b0;
            bus.o_valid <= 1'b0;
        end else begin
            bus.o_ready <= ready_d;
            bus.o_valid <= valid_d;
        end
    end

    // Operand capture, word walk with registered carry, and result/flag update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            op_q         <= 1'b0;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            bus.o_result <= '0;
            bus.o_cout   <= 1'b0;
            bus.o_ovf    <= 1'b0;
            bus.o_zero   <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= bus.i_a;
                b_q     <= bus.i_b;
                op_q    <= bus.i_add_sub;
                carry_q <= bus.i_add_sub;
                idx_q   <= '0;
            end
            if (step) begin
                res_q[idx_q] <= sl_sum;
                carry_q      <= sl_cout;
                idx_q        <= finish ? '0 : idx_q + IDX_W'(1);
            end
            if (finish) begin
                bus.o_result <= res_final;
                bus.o_cout   <= sl_cout;
                bus.o_ovf    <= (a_q[NWORDS-1][WIDTH-1] ^ sl_sum[WIDTH-1])
                              & ((b_q[NWORDS-1][WIDTH-1] ^ op_q) ^ sl_sum[WIDTH-1]);
                bus.o_zero   <= (res_final == '0);
            end
        end
    end

endmodule
